// File: rtl/aes_uart_pkg.sv
// Shared definitions for the UART-to-AES datapath: block geometry and the
// packer's output-slot states.
package aes_uart_pkg;

   localparam int unsigned AES_BLOCK_BYTES = 16;
   localparam int unsigned AES_BLOCK_W     = 128;

   typedef logic [AES_BLOCK_W-1:0] aes_block_t;

   typedef enum logic [1:0] {
      StEmpty,
      StFull,
      StFullPend
   } out_state_e;

endpackage

// File: rtl/my_axis_if.sv
// Minimal AXI4-Stream bundle (tvalid/tready/tdata/tkeep/tlast) with
// master and slave views.
interface my_axis_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned KEEP_W = 1
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tlast;

   modport master (output tvalid, tdata, tkeep, tlast, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_byte_to_block.sv
// Packs a byte stream into BLOCK_BYTES-wide blocks, first byte in the top lane,
// padding short blocks. One output slot plus one pending block in the accumulator.
module axis_byte_to_block
   import aes_uart_pkg::*;
#(
   parameter int unsigned BLOCK_BYTES = AES_BLOCK_BYTES,
   parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
   input  logic                         Clk,
   input  logic                         RstN,
   my_axis_if.slave                     s_axis,
   my_axis_if.master                    m_axis,
   output logic [$clog2(BLOCK_BYTES):0] StatusCount,
   output logic                         StatusPadded
);

   localparam int unsigned CW = $clog2(BLOCK_BYTES) + 1;
   localparam int unsigned DW = 8 * BLOCK_BYTES;
   localparam logic [CW-1:0] FULL_CNT = CW'(BLOCK_BYTES);

   out_state_e              r_state, w_state_next;
   logic [DW-1:0]           r_acc_data, w_blk_data, r_out_data;
   logic [BLOCK_BYTES-1:0]  r_acc_keep, w_blk_keep, r_out_keep;
   logic [CW-1:0]           r_count, w_cnt_next;
   logic                    r_pend_last, r_out_last, r_padded;
   logic                    w_accept, w_store, w_complete, w_drain;
   logic                    w_load_new, w_load_pend, w_hold;

   assign s_axis.tready = (r_state != StFullPend);
   assign m_axis.tvalid = (r_state != StEmpty);
   assign m_axis.tdata  = r_out_data;
   assign m_axis.tkeep  = r_out_keep;
   assign m_axis.tlast  = r_out_last;
   assign StatusCount   = r_count;
   assign StatusPadded  = r_padded;

   assign w_accept    = s_axis.tvalid && s_axis.tready;
   assign w_store     = w_accept && s_axis.tkeep[0];
   assign w_cnt_next  = r_count + CW'(w_store);
   assign w_complete  = w_accept &&
                        ((w_cnt_next == FULL_CNT) || (s_axis.tlast && (w_cnt_next != '0)));
   assign w_drain     = m_axis.tvalid && m_axis.tready;
   assign w_load_new  = w_complete && ((r_state == StEmpty) || w_drain);
   assign w_load_pend = (r_state == StFullPend) && w_drain;
   assign w_hold      = w_complete && !w_load_new;

   // Block as it would look if committed this cycle: new byte inserted, empty lanes padded.
   always_comb begin
      w_blk_data = r_acc_data;
      w_blk_keep = r_acc_keep;
      for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
         if (w_store && (i == int'(BLOCK_BYTES) - 1 - int'(r_count))) begin
            w_blk_data[8*i +: 8] = s_axis.tdata;
            w_blk_keep[i]        = 1'b1;
         end
         if (!w_blk_keep[i]) w_blk_data[8*i +: 8] = PAD_BYTE;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StEmpty:    if (w_complete) w_state_next = StFull;
         StFull: begin
            if (w_drain)         w_state_next = w_complete ? StFull : StEmpty;
            else if (w_complete) w_state_next = StFullPend;
         end
         StFullPend: if (w_drain) w_state_next = StFull;
         default:    w_state_next = StEmpty;
      endcase
   end

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) r_state <= StEmpty;
      else       r_state <= w_state_next;
   end

   // A held block stays in the accumulator with its count until the slot frees.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         r_acc_data  <= '0;
         r_acc_keep  <= '0;
         r_count     <= '0;
         r_pend_last <= 1'b0;
         r_padded    <= 1'b0;
      end else begin
         if (w_load_pend || w_load_new) begin
            r_acc_keep <= '0;
            r_count    <= '0;
         end else if (w_accept) begin
            r_acc_data <= w_blk_data;
            r_acc_keep <= w_blk_keep;
            r_count    <= w_cnt_next;
         end
         if (w_hold) r_pend_last <= s_axis.tlast;
         r_padded <= w_complete && (w_cnt_next != FULL_CNT);
      end
   end

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         r_out_data <= '0;
         r_out_keep <= '0;
         r_out_last <= 1'b0;
      end else if (w_load_pend) begin
         r_out_data <= r_acc_data;
         r_out_keep <= r_acc_keep;
         r_out_last <= r_pend_last;
      end else if (w_load_new) begin
         r_out_data <= w_blk_data;
         r_out_keep <= w_blk_keep;
         r_out_last <= s_axis.tlast;
      end
   end

endmodule

// File: tb/tb_axis_byte_to_block.sv
// Scoreboard bench for axis_byte_to_block: a byte-queue model predicts blocks,
// a negedge monitor pops and compares every output handshake.
module tb_axis_byte_to_block;
   import aes_uart_pkg::*;

   localparam int         BB  = 16;
   localparam logic [7:0] PAD = 8'h00;

   logic       Clk  = 1'b0;
   logic       RstN = 1'b0;
   logic [4:0] status_count;
   logic       status_padded;

   always #5 Clk = ~Clk;

   my_axis_if #(.DATA_W(8),   .KEEP_W(1))  s_if ();
   my_axis_if #(.DATA_W(128), .KEEP_W(16)) m_if ();

   axis_byte_to_block #(.BLOCK_BYTES(BB), .PAD_BYTE(PAD)) dut (
      .Clk          (Clk),
      .RstN         (RstN),
      .s_axis       (s_if),
      .m_axis       (m_if),
      .StatusCount  (status_count),
      .StatusPadded (status_padded)
   );

   typedef struct {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
   } blk_t;

   blk_t       exp_q[$];
   logic [7:0] cur_q[$];
   int n_checks = 0, n_errors = 0, pad_exp = 0, pad_seen = 0, ready_mode = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: collect stored bytes, close a block at 16 bytes or on tlast.
   task automatic model_beat(input logic [7:0] d, input logic k, input logic l);
      blk_t b;
      int   n;
      if (k) cur_q.push_back(d);
      n = cur_q.size();
      if (n == BB || (l && n > 0)) begin
         b.data = '0;
         b.keep = '0;
         for (int i = 0; i < BB; i++) begin
            b.data[127-8*i -: 8] = (i < n) ? cur_q[i] : PAD;
            b.keep[15-i]         = (i < n);
         end
         b.last = l;
         exp_q.push_back(b);
         if (n < BB) pad_exp++;
         cur_q.delete();
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic k, input logic l);
      bit rdy, done;
      done = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tkeep  = k;
      s_if.tlast  = l;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge Clk);
         rdy = s_if.tready;
         @(posedge Clk);
         #1;
         if (rdy) done = 1;
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: got tready=0 expected byte %h accepted", d);
      end else begin
         model_beat(d, k, l);
      end
   endtask

   task automatic idle(input int n);
      s_if.tvalid = 1'b0;
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 600; c++) begin
         if (exp_q.size() == 0 && !m_if.tvalid) break;
         @(posedge Clk);
         #1;
      end
      check("drain_queue", 128'(exp_q.size()), 128'd0);
      check("drain_tvalid", 128'(m_if.tvalid), 128'd0);
      check("pad_pulses", 128'(pad_seen), 128'(pad_exp));
   endtask

   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge Clk);
         #1;
         case (ready_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = 1'b0;
            2:       m_if.tready = ~m_if.tready;
            default: m_if.tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge Clk) begin
      blk_t e;
      if (RstN) begin
         if (status_padded) pad_seen++;
         if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_block: got %h expected no block", m_if.tdata);
            end else begin
               e = exp_q.pop_front();
               check("blk_data", m_if.tdata, e.data);
               check("blk_keep", 128'(m_if.tkeep), 128'(e.keep));
               check("blk_last", 128'(m_if.tlast), 128'(e.last));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      #12;
      check("rst_tvalid", 128'(m_if.tvalid), 128'd0);
      check("rst_tdata", m_if.tdata, 128'd0);
      check("rst_tkeep", 128'(m_if.tkeep), 128'd0);
      check("rst_tlast", 128'(m_if.tlast), 128'd0);
      check("rst_s_tready", 128'(s_if.tready), 128'd1);
      check("rst_count", 128'(status_count), 128'd0);
      check("rst_padded", 128'(status_padded), 128'd0);
      @(posedge Clk);
      #1;
      RstN = 1'b1;
      idle(2);

      // Full block 00..0F
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, i == 15);
      check("t1_tvalid", 128'(m_if.tvalid), 128'd1);
      check("t1_tdata", m_if.tdata, 128'h000102030405060708090A0B0C0D0E0F);
      check("t1_tkeep", 128'(m_if.tkeep), 128'hFFFF);
      check("t1_padded", 128'(status_padded), 128'd0);
      idle(1);
      wait_drain();

      // Short padded block
      for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1, i == 4);
      check("t2_tvalid", 128'(m_if.tvalid), 128'd1);
      check("t2_tdata", m_if.tdata, {40'hA0A1A2A3A4, 88'h0});
      check("t2_tkeep", 128'(m_if.tkeep), 128'hF800);
      check("t2_padded", 128'(status_padded), 128'd1);
      idle(1);
      wait_drain();

      // Empty packet consumed silently
      send_byte(8'h55, 1'b0, 1'b1);
      s_if.tvalid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("t3_no_tvalid", 128'(m_if.tvalid), 128'd0);
         check("t3_count", 128'(status_count), 128'd0);
         @(posedge Clk);
         #1;
      end
      for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1, 1'b0);
      idle(1);
      wait_drain();

      // Backpressure: second block pends in the accumulator
      ready_mode = 1;
      repeat (2) @(posedge Clk);
      #1;
      fork
         for (int i = 0; i < 32; i++) send_byte(8'($urandom), 1'b1, i == 31);
         begin
            repeat (45) @(posedge Clk);
            #1;
            check("t4_s_tready", 128'(s_if.tready), 128'd0);
            check("t4_count", 128'(status_count), 128'd16);
            check("t4_tvalid", 128'(m_if.tvalid), 128'd1);
            check("t4_held", m_if.tdata, exp_q[0].data);
            check("t4_queue", 128'(exp_q.size()), 128'd2);
            ready_mode = 0;
         end
      join
      idle(1);
      wait_drain();
      check("t4_s_tready_back", 128'(s_if.tready), 128'd1);

      // Toggling ready, 64 random bytes
      ready_mode = 2;
      for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b1, i == 63);
      idle(1);
      wait_drain();

      // Random keep/last/gaps with random ready
      ready_mode = 3;
      for (int i = 0; i < 160; i++) begin
         send_byte(8'($urandom), $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10);
         if ($urandom_range(0, 9) == 0) idle(1);
      end
      send_byte(8'h00, 1'b0, 1'b1);
      idle(1);
      ready_mode = 0;
      wait_drain();

      // Asynchronous reset mid-block
      for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1, 1'b0);
      idle(1);
      check("t6_count_pre", 128'(status_count), 128'd7);
      #2;
      RstN = 1'b0;
      #1;
      check("t6_tvalid", 128'(m_if.tvalid), 128'd0);
      check("t6_count", 128'(status_count), 128'd0);
      check("t6_s_tready", 128'(s_if.tready), 128'd1);
      cur_q.delete();
      @(posedge Clk);
      #1;
      RstN = 1'b1;
      for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1, i == 15);
      check("t6_tkeep", 128'(m_if.tkeep), 128'hFFFF);
      idle(1);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
